// File: rtl/pixel_sink_pkg.sv
// Shared types, constants and helpers for pixel_stream_sink and its Fletcher-16 accumulator.
package pixel_sink_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DONE  = 2'd1,
    ABORT = 2'd2
  } sink_state_e;

  localparam int unsigned SUM_W        = 8;
  localparam int unsigned ACC_W        = SUM_W + 1;
  localparam int unsigned FLETCHER_MOD = 255;

  localparam int unsigned        LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [SUM_W-1:0] sum2;
    logic [SUM_W-1:0] sum1;
  } fletcher16_t;

  // 9-bit add followed by a single conditional subtract keeps the result below 255.
  function automatic logic [SUM_W-1:0] mod255_add(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ACC_W'(FLETCHER_MOD)) begin
      s = s - ACC_W'(FLETCHER_MOD);
    end
    return s[SUM_W-1:0];
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fletcher16_acc.sv
// Fletcher-16 running sums with mod-255 reduction; sum*_c give the sums after folding in data.
module fletcher16_acc
  import pixel_sink_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [SUM_W-1:0] data,
  output logic [SUM_W-1:0] sum1_c,
  output logic [SUM_W-1:0] sum2_c
);

  logic [SUM_W-1:0] sum1_q;
  logic [SUM_W-1:0] sum2_q;
  logic [SUM_W-1:0] sum1_n;
  logic [SUM_W-1:0] sum2_n;

  always_comb begin
    sum1_n = mod255_add(sum1_q, data);
    sum2_n = mod255_add(sum2_q, sum1_n);
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      sum1_q <= '0;
      sum2_q <= '0;
    end else if (en) begin
      sum1_q <= sum1_n;
      sum2_q <= sum2_n;
    end
  end

  assign sum1_c = sum1_n;
  assign sum2_c = sum2_n;

endmodule

// File: rtl/pixel_stream_sink.sv
// Terminal pixel sink: frames IMG_WIDTH pixels, Fletcher-16 per frame, mid-frame stall timeout.
// Define PIXEL_SINK_STALL_EN to add LFSR-driven pseudo-random backpressure in RECV.
module pixel_stream_sink
  import pixel_sink_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 1024,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [7:0]                   pixel_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic                         frame_done,
  output logic [15:0]                  checksum,
  output logic [15:0]                  frame_count,
  output logic [$clog2(IMG_WIDTH)-1:0] pixel_count,
  output logic                         err_timeout
);

  localparam int unsigned PC_W   = $clog2(IMG_WIDTH);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  sink_state_e       state_q;
  sink_state_e       state_d;
  logic [PC_W-1:0]   pc_d;
  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_d;
  logic              ready_d;
  logic              done_d;
  logic              err_d;
  logic [15:0]       fc_d;
  fletcher16_t       cks_q;
  fletcher16_t       cks_d;

  logic              xfer_c;
  logic              last_c;
  logic              acc_clr_c;
  logic              stall_c;
  logic [SUM_W-1:0]  sum1_c;
  logic [SUM_W-1:0]  sum2_c;

`ifdef PIXEL_SINK_STALL_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // ready_out is registered from lfsr_d, so it tracks lfsr_q in the cycle it is seen.
  assign stall_c = (lfsr_d[1:0] == 2'b00);
`else
  assign stall_c = 1'b0;
`endif

  assign xfer_c = valid_in && ready_out;
  assign last_c = xfer_c && (pixel_count == PC_W'(IMG_WIDTH - 1));

  fletcher16_acc u_acc (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (acc_clr_c),
    .en     (xfer_c),
    .data   (pixel_in),
    .sum1_c (sum1_c),
    .sum2_c (sum2_c)
  );

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    pc_d      = pixel_count;
    idle_d    = idle_q;
    acc_clr_c = 1'b0;

    case (state_q)
      RECV: begin
        if (xfer_c) begin
          idle_d = '0;
          if (last_c) begin
            pc_d    = '0;
            state_d = DONE;
          end else begin
            pc_d = pixel_count + PC_W'(1);
          end
        end else if (pixel_count == '0) begin
          idle_d = '0;
        end else if (idle_q == IDLE_W'(TIMEOUT - 2)) begin
          // Counter would reach TIMEOUT-1 this cycle with no transfer to rescue it.
          state_d = ABORT;
          pc_d    = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      DONE, ABORT: begin
        acc_clr_c = 1'b1;
        state_d   = RECV;
      end
      default: begin
        state_d = RECV;
      end
    endcase

    ready_d = (state_d == RECV) && !stall_c;
    done_d  = last_c;
    cks_d   = cks_q;
    if (last_c) begin
      cks_d = '{sum2: sum2_c, sum1: sum1_c};
    end
    fc_d    = frame_count + 16'(last_c);
    err_d   = err_timeout || (state_d == ABORT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RECV;
      pixel_count <= '0;
      idle_q      <= '0;
      ready_out   <= 1'b0;
      frame_done  <= 1'b0;
      cks_q       <= '0;
      frame_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_count <= pc_d;
      idle_q      <= idle_d;
      ready_out   <= ready_d;
      frame_done  <= done_d;
      cks_q       <= cks_d;
      frame_count <= fc_d;
      err_timeout <= err_d;
    end
  end

  assign checksum = cks_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Self-checking bench for pixel_stream_sink: small-frame instance plus a full-width throughput instance.
module tb_pixel_stream_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_valid, a_ready, a_done, a_err;
  logic [7:0]  a_pixel;
  logic [15:0] a_cks, a_fc;
  logic [1:0]  a_pc;

  logic        b_rstn, b_valid, b_ready, b_done, b_err;
  logic [7:0]  b_pixel;
  logic [15:0] b_cks, b_fc;
  logic [9:0]  b_pc;

  pixel_stream_sink #(.IMG_WIDTH(4), .TIMEOUT(16)) u_a (
    .clk(clk), .rstn(a_rstn), .pixel_in(a_pixel), .valid_in(a_valid),
    .ready_out(a_ready), .frame_done(a_done), .checksum(a_cks),
    .frame_count(a_fc), .pixel_count(a_pc), .err_timeout(a_err)
  );

  pixel_stream_sink u_b (
    .clk(clk), .rstn(b_rstn), .pixel_in(b_pixel), .valid_in(b_valid),
    .ready_out(b_ready), .frame_done(b_done), .checksum(b_cks),
    .frame_count(b_fc), .pixel_count(b_pc), .err_timeout(b_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          m_s1, m_s2, m_n, exp_fc;
  logic [15:0] last_cks;

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_n = 0;
  endtask

  // Reference Fletcher-16 for the 4-pixel instance; pushes a checksum per completed frame.
  task automatic model_accept(input logic [7:0] p);
    m_s1 = (m_s1 + int'(p)) % 255;
    m_s2 = (m_s2 + m_s1) % 255;
    m_n++;
    if (m_n == 4) begin
      exp_q.push_back(16'((m_s2 << 8) | m_s1));
      exp_fc = (exp_fc + 1) % 65536;
      model_clear();
    end
  endtask

  // One cycle on instance A; entered and left just after a falling edge.
  task automatic cyc_a(input logic v, input logic [7:0] p, output logic acc);
    a_valid = v;
    a_pixel = p;
    acc = v && a_ready;
    @(posedge clk);
    if (acc) model_accept(p);
    @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] p);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 64) begin
      cyc_a(1'b1, p, acc);
      guard++;
    end
    n_vec++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_a: pixel %0d not accepted within 64 cycles", p);
    end
  endtask

  task automatic test_reset();
    a_rstn = 1'b0; b_rstn = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_pixel = '0; b_pixel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", a_ready); end
    n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", a_done); end
    n_vec++; if (a_cks !== 16'h0000) begin n_err++; $display("FAIL rst_cks: got %h want 0000", a_cks); end
    n_vec++; if (a_fc !== 16'h0000) begin n_err++; $display("FAIL rst_fc: got %0d want 0", a_fc); end
    n_vec++; if (a_pc !== 2'd0) begin n_err++; $display("FAIL rst_pc: got %0d want 0", a_pc); end
    n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", a_err); end
    a_rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", a_ready); end
    model_clear();
    exp_fc = 0;
  endtask

  task automatic test_four_pixel();
    logic [15:0] want;
    logic        acc;
    send_a(8'd1); send_a(8'd2); send_a(8'd3); send_a(8'd4);
    a_valid = 1'b0;
    n_vec++; if (a_done !== 1'b1) begin n_err++; $display("FAIL fp_done: got %b want 1", a_done); end
    n_vec++; if (a_cks !== 16'h140A) begin n_err++; $display("FAIL fp_cks_const: got %h want 140a", a_cks); end
    n_vec++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL fp_sb: no expected frame queued"); end
    else begin
      want = exp_q.pop_front();
      if (a_cks !== want) begin n_err++; $display("FAIL fp_sb: got %h want %h", a_cks, want); end
      last_cks = want;
    end
    n_vec++; if (a_fc !== 16'(exp_fc)) begin n_err++; $display("FAIL fp_fc: got %0d want %0d", a_fc, exp_fc); end
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL fp_bubble: got %b want 0", a_ready); end
    cyc_a(1'b0, 8'd0, acc);
    n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL fp_pulse: got %b want 0", a_done); end
  endtask

  task automatic test_mod_boundary();
    logic [15:0] want;
    logic        acc;
    repeat (4) send_a(8'hFF);
    a_valid = 1'b0;
    n_vec++; if (a_done !== 1'b1) begin n_err++; $display("FAIL mod_done: got %b want 1", a_done); end
    n_vec++; if (a_cks !== 16'h0000) begin n_err++; $display("FAIL mod_cks: got %h want 0000", a_cks); end
    n_vec++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL mod_sb: no expected frame queued"); end
    else begin
      want = exp_q.pop_front();
      if (a_cks !== want) begin n_err++; $display("FAIL mod_sb: got %h want %h", a_cks, want); end
      last_cks = want;
    end
    n_vec++; if (a_fc !== 16'(exp_fc)) begin n_err++; $display("FAIL mod_fc: got %0d want %0d", a_fc, exp_fc); end
    cyc_a(1'b0, 8'd0, acc);
  endtask

  task automatic test_timeout_boundary();
    logic [15:0] want;
    logic        acc;
    send_a(8'd10);
    repeat (14) cyc_a(1'b0, 8'd0, acc);
    cyc_a(1'b1, 8'd20, acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL tb_accept: got %b want 1", acc); end
    n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL tb_err: got %b want 0", a_err); end
    n_vec++; if (a_pc !== 2'd2) begin n_err++; $display("FAIL tb_pc: got %0d want 2", a_pc); end
    send_a(8'd30); send_a(8'd40);
    a_valid = 1'b0;
    n_vec++;
    if (exp_q.size() == 0 || a_done !== 1'b1) begin n_err++; $display("FAIL tb_frame: done %b, queued %0d", a_done, exp_q.size()); end
    else begin
      want = exp_q.pop_front();
      if (a_cks !== want) begin n_err++; $display("FAIL tb_sb: got %h want %h", a_cks, want); end
      last_cks = want;
    end
    cyc_a(1'b0, 8'd0, acc);
  endtask

  task automatic test_timeout();
    logic [15:0] want;
    logic        acc;
    send_a(8'd1); send_a(8'd2); send_a(8'd3);
    a_valid = 1'b0;
    repeat (14) cyc_a(1'b0, 8'd0, acc);
    n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", a_err); end
    repeat (2) cyc_a(1'b0, 8'd0, acc);
    n_vec++; if (a_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", a_err); end
    n_vec++; if (a_pc !== 2'd0) begin n_err++; $display("FAIL to_pc: got %0d want 0", a_pc); end
    n_vec++; if (a_cks !== last_cks) begin n_err++; $display("FAIL to_cks: got %h want %h", a_cks, last_cks); end
    n_vec++; if (a_fc !== 16'(exp_fc)) begin n_err++; $display("FAIL to_fc: got %0d want %0d", a_fc, exp_fc); end
    model_clear();
    send_a(8'd1); send_a(8'd2); send_a(8'd3); send_a(8'd4);
    a_valid = 1'b0;
    n_vec++; if (a_cks !== 16'h140A) begin n_err++; $display("FAIL to_next_cks: got %h want 140a", a_cks); end
    n_vec++;
    if (exp_q.size() == 0 || a_done !== 1'b1) begin n_err++; $display("FAIL to_next_frame: done %b, queued %0d", a_done, exp_q.size()); end
    else begin
      want = exp_q.pop_front();
      if (a_cks !== want) begin n_err++; $display("FAIL to_sb: got %h want %h", a_cks, want); end
      last_cks = want;
    end
    cyc_a(1'b0, 8'd0, acc);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] want;
    logic        acc;
    send_a(8'd7); send_a(8'd8);
    a_valid = 1'b0;
    a_rstn  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready: got %b want 0", a_ready); end
    n_vec++; if (a_pc !== 2'd0) begin n_err++; $display("FAIL rm_pc: got %0d want 0", a_pc); end
    n_vec++; if (a_cks !== 16'h0000) begin n_err++; $display("FAIL rm_cks: got %h want 0000", a_cks); end
    n_vec++; if (a_fc !== 16'h0000) begin n_err++; $display("FAIL rm_fc: got %0d want 0", a_fc); end
    n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL rm_err: got %b want 0", a_err); end
    n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rm_done: got %b want 0", a_done); end
    a_rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    exp_fc = 0;
    send_a(8'd1); send_a(8'd2); send_a(8'd3); send_a(8'd4);
    a_valid = 1'b0;
    n_vec++; if (a_cks !== 16'h140A) begin n_err++; $display("FAIL rm_next_cks: got %h want 140a", a_cks); end
    n_vec++; if (a_fc !== 16'd1) begin n_err++; $display("FAIL rm_next_fc: got %0d want 1", a_fc); end
    n_vec++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL rm_sb: no expected frame queued"); end
    else begin
      want = exp_q.pop_front();
      if (a_cks !== want) begin n_err++; $display("FAIL rm_sb: got %h want %h", a_cks, want); end
    end
    cyc_a(1'b0, 8'd0, acc);
  endtask

  // Random valid, held until accepted; every frame_done pops the scoreboard.
  task automatic test_random_frames();
    logic        pending, acc;
    logic [7:0]  pix;
    logic [15:0] want;
    int          frames, cycles, fc_start, pc_bad;
    pending = 1'b0; pix = '0; frames = 0; cycles = 0; pc_bad = 0;
    fc_start = exp_fc;
    while (frames < 100 && cycles < 4000) begin
      if (a_done === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_sb: frame_done with nothing expected"); end
        else begin
          want = exp_q.pop_front();
          if (a_cks !== want) begin n_err++; $display("FAIL rnd_sb: frame %0d got %h want %h", frames, a_cks, want); end
        end
        frames++;
      end
      if (a_pc !== 2'(m_n) && pc_bad < 5) begin
        pc_bad++;
        n_vec++; n_err++;
        $display("FAIL rnd_pc: cycle %0d got %0d want %0d", cycles, a_pc, m_n);
      end
      if (!pending) begin
        pending = ($urandom_range(0, 3) != 0);
        if (pending) pix = 8'($urandom_range(0, 255));
      end
      cyc_a(pending, pix, acc);
      if (acc) pending = 1'b0;
      cycles++;
    end
    a_valid = 1'b0;
    n_vec++; if (frames != 100) begin n_err++; $display("FAIL rnd_frames: got %0d want 100 within budget", frames); end
    n_vec++; if (a_fc !== 16'(fc_start + 100)) begin n_err++; $display("FAIL rnd_fc: got %0d want %0d", a_fc, fc_start + 100); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_left: %0d frames never completed", exp_q.size()); end
  endtask

  task automatic test_throughput();
    int          s1, s2, bidx, lows, low0, low1, dones;
    logic [15:0] exp_b, fc_end;
    logic [9:0]  pc_end;
    logic        acc;
    s1 = 0; s2 = 0;
    for (int i = 0; i < 1024; i++) begin
      s1 = (s1 + (i % 256)) % 255;
      s2 = (s2 + s1) % 255;
    end
    exp_b = 16'((s2 << 8) | s1);
    bidx = 0; lows = 0; low0 = -1; low1 = -1; dones = 0; fc_end = '0; pc_end = '0;
    b_rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2050; k++) begin
      if (b_ready !== 1'b1) begin
        if (lows == 0) low0 = k;
        if (lows == 1) low1 = k;
        lows++;
      end
      if (b_done === 1'b1) begin
        dones++;
        n_vec++; if (b_cks !== exp_b) begin n_err++; $display("FAIL tp_cks: cycle %0d got %h want %h", k, b_cks, exp_b); end
      end
      if (k == 2049) begin fc_end = b_fc; pc_end = b_pc; end
      b_valid = 1'b1;
      b_pixel = 8'(bidx);
      acc = b_ready;
      @(posedge clk);
      if (acc) bidx++;
      @(negedge clk);
    end
    b_valid = 1'b0;
    n_vec++; if (lows != 2) begin n_err++; $display("FAIL tp_lows: got %0d want 2", lows); end
    n_vec++; if (low0 != 1024) begin n_err++; $display("FAIL tp_low0: got %0d want 1024", low0); end
    n_vec++; if (low1 != 2049) begin n_err++; $display("FAIL tp_low1: got %0d want 2049", low1); end
    n_vec++; if (dones != 2) begin n_err++; $display("FAIL tp_dones: got %0d want 2", dones); end
    n_vec++; if (fc_end !== 16'd2) begin n_err++; $display("FAIL tp_fc: got %0d want 2", fc_end); end
    n_vec++; if (pc_end !== 10'd0) begin n_err++; $display("FAIL tp_pc: got %0d want 0", pc_end); end
    n_vec++; if (b_err !== 1'b0) begin n_err++; $display("FAIL tp_err: got %b want 0", b_err); end
  endtask

  initial begin
    last_cks = '0;
    test_reset();
    test_four_pixel();
    test_mod_boundary();
`ifndef PIXEL_SINK_STALL_EN
    test_timeout_boundary();
`endif
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
`ifndef PIXEL_SINK_STALL_EN
    test_throughput();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
